// File: rtl/core_boot_pkg.sv
// Shared encodings for the core boot sequencer: command types and FSM states.
package core_boot_pkg;

    typedef enum logic [1:0] {
        CMD_IMEM_WR = 2'b00,
        CMD_REG_WR  = 2'b01,
        CMD_START   = 2'b10,
        CMD_NOP     = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/core_boot_watchdog.sv
// RUN-phase watchdog: counts RUN cycles, tracks how long the core PC has been
// unchanged, and flags self-loop halt or budget expiry.
module core_boot_watchdog #(
    parameter int XLEN             = 32,
    parameter int CNT_W            = 16,
    parameter int MAX_RUN_CYCLES   = 1000,
    parameter int SELF_LOOP_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_run_en,
    input  logic             i_clear,
    input  logic [XLEN-1:0]  i_pc,
    output logic             o_halt_hit,
    output logic             o_timeout_hit,
    output logic [CNT_W-1:0] o_cycle_count
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_stable;
    logic [XLEN-1:0]  r_prev_pc;

    assign o_halt_hit    = i_run_en && (r_stable == CNT_W'(SELF_LOOP_CYCLES - 1));
    assign o_timeout_hit = i_run_en && (r_count == CNT_W'(MAX_RUN_CYCLES - 1));
    assign o_cycle_count = r_count;

    always_ff @(posedge clk) begin
        r_prev_pc <= i_pc;
    end

    // The count is not advanced on the exit edge so DONE reports the last RUN cycle index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_stable <= '0;
        end else if (i_clear) begin
            r_count  <= '0;
            r_stable <= '0;
        end else if (i_run_en) begin
            if (!o_halt_hit && !o_timeout_hit)
                r_count <= r_count + 1'b1;
            r_stable <= (i_pc == r_prev_pc) ? r_stable + 1'b1 : '0;
        end else begin
            r_stable <= '0;
        end
    end

endmodule

// File: rtl/core_boot_sequencer.sv
// Command-driven boot sequencer: preloads imem/regfile, starts the core, watches for
// halt or timeout. Optional writeback signature enabled by CORE_BOOT_SIGNATURE_EN.
module core_boot_sequencer
    import core_boot_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int ADDR_W           = 32,
    parameter int CNT_W            = 16,
    parameter int MAX_RUN_CYCLES   = 1000,
    parameter int SELF_LOOP_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        i_cmd_type,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [XLEN-1:0]   i_cmd_data,
    input  logic              i_clear,
    input  logic [XLEN-1:0]   i_pc,
    input  logic [XLEN-1:0]   i_rd_writeback,
    output logic              o_setup,
    output logic              o_inst_mem_we,
    output logic [ADDR_W-1:0] o_inst_mem_addr,
    output logic [XLEN-1:0]   o_inst_mem_data,
    output logic              o_load_reg_we,
    output logic [4:0]        o_load_reg_addr,
    output logic [XLEN-1:0]   o_load_reg_data,
    output logic [XLEN-1:0]   o_pc_start_addr,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_timeout,
    output logic              o_err,
    output logic [CNT_W-1:0]  o_cycle_count,
    output logic [XLEN-1:0]   o_signature
);

    state_e r_state;
    state_e w_state_nxt;
    cmd_e   w_cmd;
    logic   w_accept;
    logic   w_run;
    logic   w_clear;
    logic   w_halt_hit;
    logic   w_timeout_hit;

    logic              r_imem_we, r_reg_we, r_done, r_timeout, r_err;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [XLEN-1:0]   r_imem_data, r_reg_data, r_pc_start;
    logic [4:0]        r_reg_addr;

    assign w_cmd       = cmd_e'(i_cmd_type);
    assign o_cmd_ready = (r_state == ST_IDLE);
    assign w_accept    = i_cmd_valid && o_cmd_ready;
    assign w_run       = (r_state == ST_RUN);
    assign w_clear     = i_clear && (r_state != ST_IDLE);

    core_boot_watchdog #(
        .XLEN             (XLEN),
        .CNT_W            (CNT_W),
        .MAX_RUN_CYCLES   (MAX_RUN_CYCLES),
        .SELF_LOOP_CYCLES (SELF_LOOP_CYCLES)
    ) u_watchdog (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_run_en      (w_run),
        .i_clear       (w_clear),
        .i_pc          (i_pc),
        .o_halt_hit    (w_halt_hit),
        .o_timeout_hit (w_timeout_hit),
        .o_cycle_count (o_cycle_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept && w_cmd == CMD_START) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (i_clear)                          w_state_nxt = ST_IDLE;
                else if (w_halt_hit || w_timeout_hit) w_state_nxt = ST_DONE;
            end
            ST_DONE: if (i_clear) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_imem_we   <= 1'b0;
            r_imem_addr <= '0;
            r_imem_data <= '0;
            r_reg_we    <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_data  <= '0;
            r_pc_start  <= '0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_imem_we <= w_accept && (w_cmd == CMD_IMEM_WR) && (i_cmd_addr[1:0] == 2'b00);
            r_reg_we  <= w_accept && (w_cmd == CMD_REG_WR) && (i_cmd_addr[4:0] != 5'd0);
            if (w_accept && w_cmd == CMD_IMEM_WR) begin
                if (i_cmd_addr[1:0] == 2'b00) begin
                    r_imem_addr <= i_cmd_addr;
                    r_imem_data <= i_cmd_data;
                end else begin
                    r_err <= 1'b1;
                end
            end
            if (w_accept && w_cmd == CMD_REG_WR && i_cmd_addr[4:0] != 5'd0) begin
                r_reg_addr <= i_cmd_addr[4:0];
                r_reg_data <= i_cmd_data;
            end
            if (w_accept && w_cmd == CMD_START)
                r_pc_start <= XLEN'(i_cmd_addr);
            // Halt takes precedence when both conditions land on the same cycle.
            if (w_clear) begin
                r_done    <= 1'b0;
                r_timeout <= 1'b0;
            end else if (w_run && w_halt_hit) begin
                r_done <= 1'b1;
            end else if (w_run && w_timeout_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

`ifdef CORE_BOOT_SIGNATURE_EN
    logic [XLEN-1:0] r_sig;

    always_ff @(posedge clk) begin
        if (!rst_n || w_clear)
            r_sig <= '0;
        else if (w_run)
            r_sig <= {r_sig[XLEN-2:0], r_sig[XLEN-1]} ^ i_rd_writeback;
    end

    assign o_signature = r_sig;
`else
    logic w_unused_wb;
    assign w_unused_wb = ^i_rd_writeback;
    assign o_signature = '0;
`endif

    assign o_setup         = !w_run;
    assign o_busy          = w_run;
    assign o_inst_mem_we   = r_imem_we;
    assign o_inst_mem_addr = r_imem_addr;
    assign o_inst_mem_data = r_imem_data;
    assign o_load_reg_we   = r_reg_we;
    assign o_load_reg_addr = r_reg_addr;
    assign o_load_reg_data = r_reg_data;
    assign o_pc_start_addr = r_pc_start;
    assign o_done          = r_done;
    assign o_timeout       = r_timeout;
    assign o_err           = r_err;

endmodule
